// File: rtl/demux_1to3_24b.sv
// demux_1to3_24b: registered 1-to-3 valid/ready demux with saturating drop counter
module demux_1to3_24b #(
   parameter int W  = 24,
   parameter int CW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   input  logic [1:0]     in_sel,
   output logic [2:0]     out_valid,
   input  logic [2:0]     out_ready,
   output logic [3*W-1:0] out_data,
   output logic [CW-1:0]  drop_count
);
   logic [2:0]     valid_q, valid_d, load;
   logic [3*W-1:0] data_q, data_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     free, dec;
   logic           fire;
   always_comb begin
      free     = {1'b1, ~valid_q | out_ready};
      in_ready = free[in_sel];
      fire     = in_valid & in_ready;
      dec      = 4'b0001 << in_sel;
      load     = {3{fire}} & dec[2:0];
      valid_d  = (valid_q & ~out_ready) | load;
      data_d   = data_q;
      for (int c = 0; c < 3; c++)
         data_d[c*W +: W] = load[c] ? in_data : data_q[c*W +: W];
      cnt_d    = (fire && dec[3] && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end
   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign drop_count = cnt_q;
endmodule

// File: tb/tb_demux_1to3_24b.sv
// tb_demux_1to3_24b: randomized scoreboard bench for demux_1to3_24b
module tb_demux_1to3_24b;
   localparam int W  = 24;
   localparam int CW = 8;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_data = '0;
   logic [1:0]     in_sel = '0;
   logic [2:0]     out_valid;
   logic [2:0]     out_ready = '0;
   logic [3*W-1:0] out_data;
   logic [CW-1:0]  drop_count;
   int n_chk = 0;
   int n_fail = 0;
   logic [W-1:0] q [3][$];
   logic [W-1:0] ld [3] = '{default: '0};
   int dcnt = 0;
   logic acc;

   demux_1to3_24b #(.W(W), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                      input logic [2:0] r, input logic rs, output logic a);
      logic exp_rdy;
      int ch;
      @(negedge clk);
      in_valid = v; in_sel = s; in_data = d; out_ready = r; rst = rs;
      #2;
      ch = int'(s);
      exp_rdy = (ch == 3) ? 1'b1 : (q[ch].size() == 0 || r[ch]);
      chk("in_ready", in_ready, exp_rdy);
      chk("drop_count", drop_count, dcnt);
      a = v && exp_rdy && !rs;
      @(posedge clk);
      if (rs) begin
         for (int c = 0; c < 3; c++) begin
            q[c].delete();
            ld[c] = '0;
         end
         dcnt = 0;
      end else if (a) begin
         if (ch == 3) dcnt = (dcnt == 255) ? 255 : dcnt + 1;
         else begin
            q[ch].push_back(d);
            ld[ch] = d;
         end
      end
      #1;
   endtask

   initial forever begin
      @(negedge clk);
      #2;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("out_valid%0d", c), out_valid[c], q[c].size() != 0);
         chk($sformatf("out_data%0d", c), out_data[c*W +: W], ld[c]);
         if (!rst && out_valid[c] && out_ready[c]) begin
            if (q[c].size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL pop%0d: transfer %0h with nothing expected", c, out_data[c*W +: W]);
            end else chk($sformatf("pop%0d", c), out_data[c*W +: W], q[c].pop_front());
         end
      end
   end

   initial begin
      cyc(0, 0, 0, 3'b111, 1, acc);
      cyc(0, 0, 0, 3'b111, 1, acc);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_drop", drop_count, 0);
      cyc(1, 2'b00, 24'hAAAAAA, 3'b111, 0, acc);
      chk("acc_a", acc, 1);
      chk("ch0_lat", out_data[0 +: W], 24'hAAAAAA);
      cyc(1, 2'b01, 24'hBBBBBB, 3'b111, 0, acc);
      chk("ch1_lat", {out_valid[1], out_data[W +: W]}, {1'b1, 24'hBBBBBB});
      cyc(1, 2'b10, 24'hCCCCCC, 3'b111, 0, acc);
      chk("ch2_lat", {out_valid[2], out_data[2*W +: W]}, {1'b1, 24'hCCCCCC});
      cyc(0, 0, 0, 3'b111, 0, acc);
      cyc(1, 2'b01, 24'h123456, 3'b101, 0, acc);
      repeat (3) begin
         cyc(1, 2'b01, 24'h789ABC, 3'b101, 0, acc);
         chk("bp_stall", acc, 0);
         chk("bp_hold", out_data[W +: W], 24'h123456);
      end
      cyc(1, 2'b01, 24'h789ABC, 3'b111, 0, acc);
      chk("bp_acc", acc, 1);
      chk("bp_new", {out_valid[1], out_data[W +: W]}, {1'b1, 24'h789ABC});
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 2'b10, W'(i), 3'b111, 0, acc);
         chk("tp_acc", acc, 1);
         chk("tp_data", {out_valid[2], out_data[2*W +: W]}, {1'b1, W'(i)});
      end
      cyc(0, 0, 0, 3'b111, 0, acc);
      for (int i = 1; i <= 300; i++) begin
         cyc(1, 2'b11, W'($urandom), 3'b000, 0, acc);
         if (i == 255) chk("drop_255", drop_count, 255);
      end
      chk("drop_sat", drop_count, 255);
      chk("drop_nov", out_valid, 0);
      cyc(1, 2'b00, 24'hAAAAAA, 3'b000, 0, acc);
      cyc(1, 2'b01, 24'hBBBBBB, 3'b000, 0, acc);
      chk("ind_acc", acc, 1);
      chk("ind_ch0", {out_valid[0], out_data[0 +: W]}, {1'b1, 24'hAAAAAA});
      cyc(1, 2'b00, 24'hDDDDDD, 3'b000, 0, acc);
      chk("ind_full", acc, 0);
      cyc(0, 0, 0, 3'b000, 1, acc);
      repeat (5) cyc(1, 2'b11, 0, 3'b000, 0, acc);
      cyc(1, 2'b00, 24'h111111, 3'b000, 0, acc);
      cyc(1, 2'b01, 24'h222222, 3'b000, 0, acc);
      cyc(1, 2'b10, 24'h333333, 3'b000, 0, acc);
      chk("pre_rst", {out_valid, drop_count}, {3'b111, 8'd5});
      cyc(1, 2'b11, 24'h444444, 3'b000, 1, acc);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_drop", drop_count, 0);
      repeat (3000)
         cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom),
             3'($urandom_range(0, 7)), $urandom_range(0, 99) == 0, acc);
      cyc(0, 0, 0, 3'b111, 0, acc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/demux_1to3_24b.md
Name: demux_1to3_24b

Overview:
- Registered 1-to-3 demultiplexer with valid/ready handshakes. It is the distribution counterpart of the 24-bit 3:1 select muxes.
- Routes one 24-bit producer stream to one of three consumer channels, chosen per transfer by a 2-bit select.
- Each channel has a one-entry output register. Select 2'b11 is the "no destination" code: the word is accepted and discarded, and counted.
- Sits between the execute-stage result path and the three writeback/consumer ports.

Parameters:
- W, 24, data width of input and each output channel.
- CW, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  W  input word.
- in_sel  input  2  destination: 00→ch0, 01→ch1, 10→ch2, 11→drop.
- out_valid  output  3  bit c = channel c holds a word.
- out_ready  input  3  bit c = consumer c takes the word this cycle.
- out_data  output  3*W  channel c data at bits [c*W +: W].
- drop_count  output  CW  count of accepted sel=11 words, saturating.

Behaviour:
- Clock and reset: everything is sampled on rising clk. rst is synchronous, active-high, and overrides all other activity.
- Reset values: out_valid=3'b000, out_data=0, drop_count=0.
- Reset mid-transfer: any word held in a channel is lost, with no output transfer. In-flight input in the reset cycle is not accepted for counting purposes.
- Acceptance: in_fire = in_valid & in_ready.
- in_ready is combinational from in_sel and the channel state:
  - sel=c (0..2): in_ready = ~out_valid[c] | out_ready[c].
  - sel=11: in_ready = 1.
  - in_ready is a function of in_sel even when in_valid=0.
- Load: on in_fire with sel=c, out_data[c] <= in_data and out_valid[c] <= 1 at the next edge. Latency is 1 cycle from accept to out_valid.
- Drain: when out_valid[c] & out_ready[c] and channel c is not loaded this cycle, out_valid[c] <= 0. out_data[c] keeps its last value.
- Simultaneous drain and load on the same channel: the new word replaces the old one and out_valid[c] stays 1. This gives full throughput, one word per cycle per channel.
- Channels are independent. A load into one channel never disturbs another. Multiple channels may drain in the same cycle.
- Hold rule: while out_valid[c] & ~out_ready[c], out_data[c] and out_valid[c] are stable.
- Full channel: if sel=c, out_valid[c]=1 and out_ready[c]=0, then in_ready=0. The word is not accepted, the producer must hold, and there is no drop and no count.
- Drop: in_fire with sel=11 increments drop_count by 1. It saturates at 2^CW-1 (255 by default) and does not wrap. No channel changes.
- in_valid=0: no state change except drains.
- Invariant: out_valid[c] never rises without an in_fire to channel c in the previous cycle.

Test Plan:
1. Reset, then single routes:
   - Stimulus: assert rst 2 cycles; send 24'hAAAAAA sel=00, 24'hBBBBBB sel=01, 24'hCCCCCC sel=10 on consecutive cycles, out_ready=3'b111.
   - Required: out_valid=000 and drop_count=0 after reset. Each word appears on its own channel exactly 1 cycle after its accept, with in_ready=1 throughout.
2. Backpressure:
   - Stimulus: out_ready[1]=0; send 24'h123456 sel=01, then 24'h789ABC sel=01 for 3 cycles; then raise out_ready[1].
   - Required: ch1 holds 123456 stable and in_ready=0 while out_ready[1] is low. Raising out_ready[1] drains 123456 and accepts 789ABC in the same cycle; ch1 shows 789ABC the next cycle with out_valid[1] staying 1.
3. Full throughput:
   - Stimulus: stream 8 words 24'h000001..24'h000008 to sel=10 with out_ready[2]=1.
   - Required: in_ready=1 every cycle, out_valid[2] high 8 consecutive cycles, data in order.
4. Drop and saturation:
   - Stimulus: send 300 words sel=11.
   - Required: in_ready=1 always, out_valid unchanged, drop_count=255 after the 255th and still 255 at the end.
5. Channel independence:
   - Stimulus: ch0 full and stalled (out_ready[0]=0) holding 24'hAAAAAA; send 24'hBBBBBB sel=01.
   - Required: accepted, ch1=BBBBBB, ch0 still AAAAAA valid. A subsequent sel=00 word gets in_ready=0.
6. Reset mid-operation:
   - Stimulus: all 3 channels valid and stalled, drop_count=5; assert rst 1 cycle while in_valid=1 sel=11.
   - Required: the next cycle has out_valid=000, out_data=0, drop_count=0.
